pea_firing_scheduler: RTL and testbench
=======================================

# pea_firing_scheduler

Autonomous firing sequencer for the PEA actor. Replaces hand-driven bench sequencing of `invoke`/`next_instr` with a state machine. Alternates SETUP_INSTR (GC) and INSTR firings, gating each on `PEA_enable`'s `enable` and completing on a rising edge of `PEA_top_module_1`'s `FC`. Sits between the system controller and the PEA invoke/enable pair.

## Interface
- `SETTLE_CYC`, default 1 — cycles `next_instr` is held stable before `enable` is sampled (≥1).
- `FC_TIMEOUT`, default 4096 — max cycles in WAIT_FC before ERROR; 0 disables the watchdog.
- `CNT_W`, default 16 — width of `instr_count`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  start request, pulse or level; sampled only in IDLE.
- `stop`  in  1  one-cycle pulse; latched as `stop_pending`.
- `clear_err`  in  1  leave ERROR.
- `enable`  in  1  from PEA_enable for the current `next_instr`.
- `FC`  in  1  firing-complete from PEA top.
- `invoke`  out  1  one-cycle firing pulse to PEA top.
- `next_instr`  out  2  mode to PEA top/enable: 2'b00 SETUP_INSTR, 2'b01 INSTR. 2'b10 (OUTPUT) is never driven.
- `busy`  out  1  high in every state except IDLE and ERROR.
- `stalled`  out  1  high while in CHECK with `enable` low.
- `error`  out  1  high in ERROR.
- `instr_count`  out  CNT_W  completed INSTR firings; wraps modulo 2^CNT_W.

## Operation
States: IDLE, SETTLE, CHECK, INVOKE, WAIT_FC, ERROR.
- IDLE: `next_instr`=00. On `run` with no `stop` in the same cycle → SETTLE, settle counter cleared. `stop` in IDLE has priority and keeps the block in IDLE.
- SETTLE: count SETTLE_CYC cycles → CHECK.
- CHECK:
  - If `stop_pending` and `next_instr`=00 → IDLE, clear `stop_pending`. Stop is honored only at an instruction boundary, so a GC/INSTR pair is never split.
  - Else if `enable` → INVOKE.
  - Else stay in CHECK with `stalled`=1. There is no timeout on stalls.
- INVOKE: `invoke`=1 for exactly this cycle → WAIT_FC, watchdog counter cleared.
- WAIT_FC:
  - `fc_q` registers `FC` every cycle. Completion = `FC & ~fc_q`.
  - On completion: toggle `next_instr`. If the finished mode was INSTR, `instr_count`+1. → SETTLE.
  - Else if FC_TIMEOUT≠0 and the watchdog reaches FC_TIMEOUT → ERROR.
- ERROR: `next_instr` held. On `clear_err` → IDLE, `next_instr`=00, `stop_pending` cleared.
- `stop` pulses in any non-IDLE state set `stop_pending`. `stop` while already pending has no further effect.
- `run` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, `invoke` 0, `next_instr` 00, `busy` 0, `stalled` 0, `error` 0, `instr_count` 0, `stop_pending` 0, `fc_q` 0.
- All outputs are registered or decoded from state only. There is no combinational path from `enable`/`FC` to `invoke`.
- Invoke latency: with `run` sampled at edge k and `enable` high, CHECK is entered at k+SETTLE_CYC, and `invoke` is high from edge k+SETTLE_CYC+1 to k+SETTLE_CYC+2.
- Post-FC: FC rise sampled at edge m puts the new `next_instr` on the output from edge m, and the next `invoke` at m+SETTLE_CYC+1 at the earliest.
- A stale FC already high when WAIT_FC is entered does not complete the firing. FC must fall and rise again.
- `stop` and FC rise in the same cycle: completion is processed and stop is latched. The boundary check happens in the following CHECK.
- Watchdog: ERROR is entered at the edge where the count equals FC_TIMEOUT, counted from WAIT_FC entry.
- `rst` in any state returns all reset values at the next edge. An in-flight firing is abandoned.

## Test plan
- Reset, `run`, `enable`=1, FC model rising 5 cycles after each `invoke`. Expect `invoke` pulses with `next_instr` 00,01,00,01. `instr_count`=1 after the 2nd FC, 2 after the 4th. Invoke-to-invoke spacing is exactly 5+SETTLE_CYC+1 cycles.
- Hold `enable`=0 for 20 cycles in CHECK. Expect `stalled`=1, no `invoke`, `busy`=1. Raise `enable`: `invoke` on the next cycle and `stalled`=0.
- Pulse `stop` during the INSTR WAIT_FC. Expect the firing to complete, `instr_count`+1, return to IDLE with `next_instr`=00 and `busy`=0. No further `invoke`.
- FC_TIMEOUT=16, FC never rises. Expect `error`=1 exactly 16 cycles after WAIT_FC entry, and `invoke`=0 thereafter. `clear_err` → IDLE with `error`=0.
- FC held high through INVOKE. Expect no completion. FC low 1 cycle then high → `next_instr` toggles.
- Assert `rst` mid-WAIT_FC with `instr_count`=3. Next cycle all outputs are at reset values and `instr_count`=0.

Source files
------------

// File: rtl/pea_firing_scheduler.sv
// Autonomous GC/INSTR firing sequencer for the PEA actor: gates each firing on enable and
// completes it on a rising edge of FC, with an optional FC watchdog.
module pea_firing_scheduler #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned FC_TIMEOUT = 4096,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             stop_i,
  input  logic             clear_err_i,
  input  logic             enable_i,
  input  logic             fc_i,
  output logic             invoke_o,
  output logic [1:0]       next_instr_o,
  output logic             busy_o,
  output logic             stalled_o,
  output logic             error_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCheck,
    StInvoke,
    StWaitFc,
    StError
  } state_e;

  localparam logic [1:0] ModeSetup = 2'b00;
  localparam logic [1:0] ModeInstr = 2'b01;

  state_e           state_q, state_d;
  logic [31:0]      settle_q, settle_d;
  logic [31:0]      wd_q, wd_d;
  logic [1:0]       instr_q, instr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stop_pend_q, stop_pend_d;
  logic             stalled_q, stalled_d;
  logic             fc_q;
  logic             invoke_q, busy_q, error_q;
  logic             fc_rise;

  assign fc_rise = fc_i & ~fc_q;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    wd_d        = wd_q;
    instr_d     = instr_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q;
    stalled_d   = 1'b0;

    if (stop_i && (state_q != StIdle)) begin
      stop_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        instr_d = ModeSetup;
        if (run_i && !stop_i) begin
          state_d  = StSettle;
          settle_d = '0;
        end
      end
      StSettle: begin
        if (settle_q == SETTLE_CYC - 1) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + 32'd1;
        end
      end
      StCheck: begin
        // Stop only at a GC boundary so a GC/INSTR pair is never split.
        if (stop_pend_q && (instr_q == ModeSetup)) begin
          state_d     = StIdle;
          stop_pend_d = 1'b0;
        end else if (enable_i) begin
          state_d = StInvoke;
        end else begin
          stalled_d = 1'b1;
        end
      end
      StInvoke: begin
        state_d = StWaitFc;
        wd_d    = '0;
      end
      StWaitFc: begin
        if (fc_rise) begin
          instr_d  = {1'b0, ~instr_q[0]};
          state_d  = StSettle;
          settle_d = '0;
          if (instr_q == ModeInstr) begin
            count_d = count_q + CNT_W'(1);
          end
        end else if ((FC_TIMEOUT != 0) && (wd_q == FC_TIMEOUT - 1)) begin
          state_d = StError;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      StError: begin
        if (clear_err_i) begin
          state_d     = StIdle;
          instr_d     = ModeSetup;
          stop_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      wd_q        <= '0;
      instr_q     <= ModeSetup;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
      stalled_q   <= 1'b0;
      fc_q        <= 1'b0;
      invoke_q    <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      wd_q        <= wd_d;
      instr_q     <= instr_d;
      count_q     <= count_d;
      stop_pend_q <= stop_pend_d;
      stalled_q   <= stalled_d;
      fc_q        <= fc_i;
      // Outputs registered from the next state so they line up with the state register.
      invoke_q    <= (state_d == StInvoke);
      busy_q      <= (state_d != StIdle) && (state_d != StError);
      error_q     <= (state_d == StError);
    end
  end

  assign invoke_o      = invoke_q;
  assign next_instr_o  = instr_q;
  assign busy_o        = busy_q;
  assign stalled_o     = stalled_q;
  assign error_o       = error_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_pea_firing_scheduler.sv
// Directed and randomized bench for pea_firing_scheduler; expectations come from firing-count
// and cycle-arithmetic models of the sequencing rules.
module tb_pea_firing_scheduler;

  localparam int S  = 2;
  localparam int TO = 16;

  logic        clk, rst, run, stop, clear_err, enable, fc;
  logic        invoke, busy, stalled, error;
  logic [1:0]  next_instr;
  logic [15:0] instr_count;

  int          cyc, n_chk, n_fail, fires, inv_cyc, exp_inv;
  logic [15:0] cnt_m;
  logic        any;

  pea_firing_scheduler #(
    .SETTLE_CYC(S),
    .FC_TIMEOUT(TO),
    .CNT_W     (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .stop_i       (stop),
    .clear_err_i  (clear_err),
    .enable_i     (enable),
    .fc_i         (fc),
    .invoke_o     (invoke),
    .next_instr_o (next_instr),
    .busy_o       (busy),
    .stalled_o    (stalled),
    .error_o      (error),
    .instr_count_o(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Steps until invoke is seen; checks its cycle (if predicted) and the mode being fired.
  task automatic wait_invoke();
    int n = 0;
    while (invoke !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("invoke_seen", {31'b0, invoke}, 32'd1);
    inv_cyc = cyc;
    if (exp_inv >= 0) chk("invoke_cycle", inv_cyc, exp_inv);
    chk("invoke_mode", {30'b0, next_instr}, fires % 2);
  endtask

  // FC rises so that it is sampled dly edges after the invoke edge.
  task automatic complete(input int dly, input bit do_stop);
    for (int j = 1; j < dly; j++) begin
      step();
      if (j == 1) chk("invoke_one_cycle", {31'b0, invoke}, 32'd0);
      stop = (do_stop && j == 2);
    end
    stop = 1'b0;
    fc   = 1'b1;
    step();
    if (fires % 2 == 1) cnt_m++;
    fires++;
    chk("mode_toggle", {30'b0, next_instr}, fires % 2);
    chk("instr_count", {16'b0, instr_count}, {16'b0, cnt_m});
    fc = 1'b0;
  endtask

  // Drops enable for r cycles after a completion and predicts the next invoke cycle.
  task automatic gap(input int r);
    int m = cyc;
    if (r > 0) begin
      enable = 1'b0;
      repeat (r) step();
      enable = 1'b1;
    end
    exp_inv = m + 1 + ((r > S) ? r : S);
  endtask

  task automatic start_run();
    fires   = 0;
    exp_inv = cyc + 2 + S;
    run     = 1'b1;
    step();
    run     = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_invoke"}, {31'b0, invoke}, 32'd0);
    chk({tag, "_next_instr"}, {30'b0, next_instr}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_stalled"}, {31'b0, stalled}, 32'd0);
    chk({tag, "_error"}, {31'b0, error}, 32'd0);
    chk({tag, "_count"}, {16'b0, instr_count}, 32'd0);
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; fires = 0; cnt_m = '0; exp_inv = -1;
    rst = 1'b1; run = 1'b0; stop = 1'b0; clear_err = 1'b0; enable = 1'b1; fc = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Fixed FC delay of 5: invoke spacing must be 5+S+1.
    start_run();
    for (int f = 0; f < 4; f++) begin
      wait_invoke();
      chk("busy_firing", {31'b0, busy}, 32'd1);
      complete(5, 1'b0);
      gap(0);
      if (f > 0) chk("spacing", exp_inv - inv_cyc, 5 + S + 1);
    end
    chk("count_after_4", {16'b0, instr_count}, 32'd2);

    // Random FC delays and enable dropouts.
    for (int f = 0; f < 10; f++) begin
      wait_invoke();
      complete($urandom_range(3, 9), 1'b0);
      gap($urandom_range(0, 6));
    end

    // Long stall in CHECK.
    wait_invoke();
    complete(4, 1'b0);
    enable = 1'b0;
    repeat (S) step();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("stall_stalled", {31'b0, stalled}, 32'd1);
      chk("stall_no_invoke", {31'b0, invoke}, 32'd0);
      chk("stall_busy", {31'b0, busy}, 32'd1);
    end
    enable  = 1'b1;
    exp_inv = cyc + 1;
    wait_invoke();
    chk("unstall_stalled", {31'b0, stalled}, 32'd0);
    complete(5, 1'b0);
    gap(0);

    // Stop during an INSTR firing: pair completes, then IDLE.
    while (fires % 2 == 0) begin
      wait_invoke();
      complete(5, 1'b0);
      gap(0);
    end
    wait_invoke();
    complete(6, 1'b1);
    repeat (S + 1) step();
    chk("stop_busy", {31'b0, busy}, 32'd0);
    chk("stop_next_instr", {30'b0, next_instr}, 32'd0);
    any = 1'b0;
    repeat (12) begin
      step();
      if (invoke) any = 1'b1;
    end
    chk("stop_no_invoke", {31'b0, any}, 32'd0);

    // Watchdog: FC never rises.
    start_run();
    wait_invoke();
    any = 1'b0;
    repeat (TO) begin
      step();
      if (invoke || error) any = 1'b1;
    end
    chk("wd_quiet_before", {31'b0, any}, 32'd0);
    step();
    chk("wd_error", {31'b0, error}, 32'd1);
    chk("wd_busy", {31'b0, busy}, 32'd0);
    any = 1'b0;
    repeat (5) begin
      step();
      if (invoke || !error) any = 1'b1;
    end
    chk("wd_hold", {31'b0, any}, 32'd0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clr_error", {31'b0, error}, 32'd0);
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_next_instr", {30'b0, next_instr}, 32'd0);

    // Stale FC held high through INVOKE must not complete.
    fc = 1'b1;
    start_run();
    wait_invoke();
    repeat (8) step();
    chk("stale_no_toggle", {30'b0, next_instr}, 32'd0);
    chk("stale_busy", {31'b0, busy}, 32'd1);
    fc = 1'b0;
    step();
    fc = 1'b1;
    step();
    chk("stale_toggle", {30'b0, next_instr}, 32'd1);
    fc = 1'b0;

    // Reset mid WAIT_FC with instr_count = 3.
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_m = '0;
    chk_reset_vals("rst1");
    start_run();
    for (int f = 0; f < 6; f++) begin
      wait_invoke();
      complete($urandom_range(3, 8), 1'b0);
      gap($urandom_range(0, 4));
    end
    wait_invoke();
    step();
    step();
    chk("pre_rst_count", {16'b0, instr_count}, 32'd3);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    chk_reset_vals("rst2");
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
